rsa_mod_exp: RTL
================

Name: rsa_mod_exp

Overview:
- Bit-serial modular exponentiation engine: computes result = base^exponent mod modulus.
- Sits directly downstream of the modular-inverse stage. The private exponent d from the inverse stage is fed in as `exponent` for decryption/signing. The public exponent e is used for encryption.
- Constant-time: latency is independent of exponent and base values, to avoid timing side channels.

Parameters:
- WIDTH, 32, operand width in bits for base, exponent, modulus and result.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse. Sampled only when busy=0.
- base  input  WIDTH  message/ciphertext. May be >= modulus.
- exponent  input  WIDTH  exponent (e or d).
- modulus  input  WIDTH  modulus n.
- busy  output  1  high from the edge that accepts start until the edge that asserts result_valid.
- result  output  WIDTH  base^exponent mod modulus. Meaningful while result_valid=1.
- result_valid  output  1  level. High from completion until the next accepted start or reset.
- err  output  1  high with result_valid when modulus==0.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - busy=0, result=0, result_valid=0, err=0.
  - All internal registers are zero. FSM is in IDLE.
- Reset mid-operation aborts the computation immediately. No partial result is ever exposed.
- Accept: start=1 && busy=0 at edge E0. On that edge:
  - latch base, exponent and modulus;
  - clear result_valid and err;
  - set busy.
- start while busy=1 is ignored. Latched operands are unaffected.
- Inputs may change freely after E0.
- FSM states: IDLE, REDUCE, SQUARE, MULT, DONE.
- Short path, modulus < 2:
  - IDLE -> DONE.
  - result=0; err=1 if modulus==0, else err=0.
  - result_valid=1 and busy=0 after edge E0+1.
- Normal path, IDLE -> REDUCE:
  - REDUCE: b = base mod modulus, computed as modmul(base, 1). Takes WIDTH cycles.
  - r initialised to 1.
  - Exponent bits are processed MSB first; all WIDTH bits are processed regardless of leading zeros.
  - For each bit: SQUARE, r = modmul(r, r), WIDTH cycles; then MULT, t = modmul(r, b), WIDTH cycles.
  - After MULT: r <= t if the exponent bit is 1, else r is unchanged. t is always computed (constant time).
  - After the last MULT of bit 0 -> DONE. DONE drives result=r, result_valid=1, busy=0, then -> IDLE.
- Latency, normal path: result_valid=1 after edge E0+L, with L = 2*WIDTH*WIDTH + WIDTH + 1. For WIDTH=32, L=2081, independent of operand values.
- modmul(a, y) for y < m is interleaved shift-add, one cycle per bit of a, MSB first:
  - acc starts at 0.
  - Each cycle: acc = 2*acc + a_bit*y, then subtract m at most twice so that acc < m.
  - Intermediate width is WIDTH+2 bits. The final acc < m.
  - No multiplier or divider is inferred.
- exponent==0 gives result=1 (modulus >= 2).
- base==0 with exponent>0 gives 0.
- base >= modulus is handled by REDUCE.
- modulus at its maximum value, 2^WIDTH-1, must not overflow.
- Back-to-back operation: a start on the cycle result_valid is high is accepted. result_valid drops on the accepting edge.

Test Plan:
- Basic value and latency: base=4, exp=13, mod=497, start pulse -> result=445, err=0; result_valid exactly 2081 cycles after accept; busy high throughout.
- RSA round-trip with the inverse-stage output:
  - n=3233, e=17, d=2753.
  - base=65, exp=17 -> 2790.
  - Then base=2790, exp=2753 -> 65.
  - Both runs take 2081 cycles.
- Reduction and edge exponents:
  - base=1000, exp=1, mod=7 -> 6.
  - base=1000, exp=0, mod=7 -> 1.
  - base=0, exp=5, mod=7 -> 0.
- Degenerate modulus:
  - mod=0 -> err=1, result=0, result_valid one cycle after accept.
  - mod=1 -> err=0, result=0, same timing.
- Protocol and reset:
  - Pulse start with different operands at cycle 100 of a run -> ignored; original answer returned.
  - Assert rst_n=0 at cycle 500 -> busy=0, result=0, result_valid=0 immediately. A new start then yields the correct result.
- Full width: mod=0xFFFFFFFB (prime), base=2, exp=0xFFFFFFFA -> result=1 (Fermat). Random 32-bit vectors match the reference model.

Source files
------------

// File: rtl/rsa_mod_exp.sv
// Bit-serial modular exponentiation: result = base^exponent mod modulus.
// Left-to-right square-and-always-multiply over all WIDTH exponent bits, so the
// latency depends only on WIDTH (2*WIDTH*WIDTH + WIDTH + 1 cycles) and never on
// operand values. Each modular product uses interleaved shift-add reduction.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : request pulse, accepted only while busy=0
//   base          : message/ciphertext, may be >= modulus
//   exponent      : public or private exponent
//   modulus       : modulus n
//   busy          : operation in progress
//   result        : base^exponent mod modulus, valid while result_valid=1
//   result_valid  : level, high from completion until next accepted start
//   err           : high with result_valid when modulus was zero
module rsa_mod_exp #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             err
);

    localparam int unsigned AW = WIDTH + 2;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REDUCE = 3'd1,
        SQUARE = 3'd2,
        MULT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mod_q;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic [AW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    bit_q;

    logic             last_cyc;
    logic [AW-1:0]    m_ext;
    logic [AW-1:0]    y_ext;
    logic [AW-1:0]    s0, s1, acc_d;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] mult_r;

    // One shift-add-reduce step of modmul; acc < m keeps 2*acc + y < 3m.
    always_comb begin
        m_ext  = AW'(mod_q);
        y_ext  = a_sh_q[WIDTH-1] ? AW'(y_q) : '0;
        s0     = (acc_q << 1) + y_ext;
        s1     = (s0 >= m_ext) ? (s0 - m_ext) : s0;
        acc_d  = (s1 >= m_ext) ? (s1 - m_ext) : s1;
        prod   = acc_d[WIDTH-1:0];
        // Product is always formed; only the update of r depends on the bit.
        mult_r = exp_q[WIDTH-1] ? prod : r_q;
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        last_cyc = (cnt_q == LAST);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (modulus < WIDTH'(2)) ? DONE : REDUCE;
                end
            end
            REDUCE: begin
                if (last_cyc) state_d = SQUARE;
            end
            SQUARE: begin
                if (last_cyc) state_d = MULT;
            end
            MULT: begin
                if (last_cyc) state_d = (bit_q == LAST) ? DONE : SQUARE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mod_q        <= '0;
            exp_q        <= '0;
            a_sh_q       <= '0;
            y_q          <= '0;
            b_q          <= '0;
            r_q          <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            bit_q        <= '0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mod_q        <= modulus;
                        exp_q        <= exponent;
                        a_sh_q       <= base;
                        y_q          <= WIDTH'(1);
                        b_q          <= '0;
                        r_q          <= '0;
                        acc_q        <= '0;
                        cnt_q        <= '0;
                        bit_q        <= '0;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                        err          <= 1'b0;
                    end
                end
                REDUCE: begin
                    acc_q  <= acc_d;
                    a_sh_q <= a_sh_q << 1;
                    cnt_q  <= cnt_q + CW'(1);
                    if (last_cyc) begin
                        // b = base mod m; r starts at 1, first square is 1*1.
                        b_q    <= prod;
                        r_q    <= WIDTH'(1);
                        a_sh_q <= WIDTH'(1);
                        y_q    <= WIDTH'(1);
                        acc_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                SQUARE: begin
                    acc_q  <= acc_d;
                    a_sh_q <= a_sh_q << 1;
                    cnt_q  <= cnt_q + CW'(1);
                    if (last_cyc) begin
                        r_q    <= prod;
                        a_sh_q <= prod;
                        y_q    <= b_q;
                        acc_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                MULT: begin
                    acc_q  <= acc_d;
                    a_sh_q <= a_sh_q << 1;
                    cnt_q  <= cnt_q + CW'(1);
                    if (last_cyc) begin
                        r_q    <= mult_r;
                        a_sh_q <= mult_r;
                        y_q    <= mult_r;
                        exp_q  <= exp_q << 1;
                        bit_q  <= bit_q + CW'(1);
                        acc_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                DONE: begin
                    result       <= r_q;
                    err          <= (mod_q == '0);
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
